// File: rtl/tcp_sender_if.sv
// Shared types for the TCP frame builder: the packet descriptor and the
// byte-wide AXI-Stream interface.
// Ports (interface): tdata/tvalid/tlast from the source, tready from the sink.
package tcp_sender_pkg;
  typedef struct packed {
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  tcp_flags;
    logic [15:0] window;
    logic [15:0] payload_len;
    logic [15:0] tcp_checksum;  // folded one's-complement sum of payload only
  } tcp_packet_info_s;
endpackage

interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tcp_sender.sv
// Purpose: builds an Ethernet II / IPv4 / TCP frame + payload + FCS, one byte per beat.
// Latency: first header byte is valid the cycle after start; 1 byte/cycle when unstalled.
// Backpressure: stalls on m_axis.tready; payload tready mirrors m_axis.tready in PAYLOAD.
// Ports: clk, rst_n (async, active low), start + i_pkt (descriptor latched in IDLE),
//        s_axis (payload in), m_axis (frame out, tlast on last FCS byte), busy.
module tcp_sender
  import tcp_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  tcp_packet_info_s i_pkt,
  axi_stream_if.slave      s_axis,
  axi_stream_if.master     m_axis,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FCS} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      crc_q, crc_d;
  tcp_packet_info_s pkt_q, pkt_d;

  logic [15:0]           ip_len, tcp_len, ip_csum, tcp_csum;
  logic [31:0]           ip_sum, tcp_sum, crc_inv;
  logic [431:0]          hdr_vec;
  logic [7:0]            hdr_byte, fcs_byte;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld, out_last, pay_rdy;
  logic                  unused_tlast;

  // Payload length alone decides where the payload ends.
  assign unused_tlast = s_axis.tlast;

  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    t = {16'h0, t[15:0]} + {16'h0, t[31:16]};  // second pass absorbs the carry of the first
    return t[15:0];
  endfunction

  // Reflected CRC-32 (0xEDB88320), LSB of the byte first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Checksums are pure functions of the latched descriptor, so they are
  // stable for the whole frame, well before bytes 24 and 50 go out.
  always_comb begin
    ip_len  = 16'd40 + pkt_q.payload_len;
    tcp_len = 16'd20 + pkt_q.payload_len;
    ip_sum  = 32'h0000_4500 + {16'h0, ip_len} + 32'h0000_4000 + 32'h0000_4006
            + {16'h0, pkt_q.src_ip[31:16]} + {16'h0, pkt_q.src_ip[15:0]}
            + {16'h0, pkt_q.dst_ip[31:16]} + {16'h0, pkt_q.dst_ip[15:0]};
    ip_csum = ~fold16(ip_sum);
    tcp_sum = {16'h0, pkt_q.src_ip[31:16]} + {16'h0, pkt_q.src_ip[15:0]}
            + {16'h0, pkt_q.dst_ip[31:16]} + {16'h0, pkt_q.dst_ip[15:0]}
            + 32'h0000_0006 + {16'h0, tcp_len}
            + {16'h0, pkt_q.src_port} + {16'h0, pkt_q.dst_port}
            + {16'h0, pkt_q.seq_num[31:16]} + {16'h0, pkt_q.seq_num[15:0]}
            + {16'h0, pkt_q.ack_num[31:16]} + {16'h0, pkt_q.ack_num[15:0]}
            + {16'h0, 8'h50, pkt_q.tcp_flags} + {16'h0, pkt_q.window}
            + {16'h0, pkt_q.tcp_checksum};
    tcp_csum = ~fold16(tcp_sum);
    // Byte 0 sits in the top octet.
    hdr_vec = {pkt_q.dst_mac, pkt_q.src_mac, 16'h0800,
               16'h4500, ip_len, 16'h0000, 16'h4000, 8'h40, 8'h06, ip_csum,
               pkt_q.src_ip, pkt_q.dst_ip,
               pkt_q.src_port, pkt_q.dst_port, pkt_q.seq_num, pkt_q.ack_num,
               8'h50, pkt_q.tcp_flags, pkt_q.window, tcp_csum, 16'h0000};
    hdr_byte = hdr_vec[{(6'd53 - cnt_q[5:0]), 3'b000} +: 8];
    crc_inv  = ~crc_q;
    fcs_byte = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      pkt_q   <= pkt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    pkt_d    = pkt_q;
    out_vld  = 1'b0;
    out_dat  = '0;
    out_last = 1'b0;
    pay_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pkt_d   = i_pkt;
          cnt_d   = '0;
          crc_d   = 32'hFFFF_FFFF;
          state_d = HDR;
        end
      end
      HDR: begin
        out_vld = 1'b1;
        out_dat = hdr_byte;
        if (m_axis.tready) begin
          crc_d = crc_step(crc_q, hdr_byte);
          if (cnt_q == 16'd53) begin
            cnt_d   = '0;
            state_d = (pkt_q.payload_len == 16'd0) ? FCS : PAYLOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      PAYLOAD: begin
        pay_rdy = m_axis.tready;
        out_vld = s_axis.tvalid;
        out_dat = s_axis.tdata;
        if (s_axis.tvalid && m_axis.tready) begin
          crc_d = crc_step(crc_q, s_axis.tdata);
          if (cnt_q == pkt_q.payload_len - 16'd1) begin
            cnt_d   = '0;
            state_d = FCS;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      FCS: begin
        out_vld  = 1'b1;
        out_dat  = fcs_byte;
        out_last = (cnt_q[1:0] == 2'd3);
        if (m_axis.tready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_q[1:0] == 2'd3) ? IDLE : FCS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tlast  = out_last;
  assign s_axis.tready = pay_rdy;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_tcp_sender.sv
module tb_tcp_sender;
  import tcp_sender_pkg::*;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  tcp_packet_info_s i_pkt;
  logic             busy;

  axi_stream_if #(.DATA_WIDTH(8)) s_if ();
  axi_stream_if #(.DATA_WIDTH(8)) m_if ();

  tcp_sender #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_pkt(i_pkt),
    .s_axis(s_if), .m_axis(m_if), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] crc_tab [256];

  // Results of the last run_frame call.
  bq_t  got;
  bit   lasts[$];
  int   cycles, first_lat, hold_viol, idle_viol, sready_viol, taken;
  bit   timed_out, aborted;
  logic [11:0] rst_snap;

  // ---------------- reference model ----------------
  task automatic init_crc_tab();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  function automatic logic [15:0] oc_sum(input bq_t b);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < b.size(); i += 2) begin
      logic [7:0] lo;
      lo = (i + 1 < b.size()) ? b[i+1] : 8'h00;
      s += {16'h0, b[i], lo};
    end
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic bq_t to_bytes(input logic [159:0] v, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[(n-1-i)*8 +: 8]);
    return q;
  endfunction

  function automatic bq_t build_frame(input tcp_packet_info_s p, input bq_t pl);
    bq_t f, ih, th, ps;
    logic [15:0] ip_len, tcp_len, ck;
    logic [31:0] c;
    ip_len  = 16'd40 + p.payload_len;
    tcp_len = 16'd20 + p.payload_len;
    f  = to_bytes({48'h0, p.dst_mac, p.src_mac, 16'h0800}, 14);
    ih = to_bytes({16'h4500, ip_len, 16'h0000, 16'h4000, 8'h40, 8'h06, 16'h0000,
                   p.src_ip, p.dst_ip}, 20);
    ck = ~oc_sum(ih);
    ih[10] = ck[15:8];
    ih[11] = ck[7:0];
    th = to_bytes({p.src_port, p.dst_port, p.seq_num, p.ack_num, 8'h50, p.tcp_flags,
                   p.window, 16'h0000, 16'h0000}, 20);
    ps = to_bytes({64'h0, p.src_ip, p.dst_ip, 16'h0006, tcp_len}, 12);
    foreach (th[i]) ps.push_back(th[i]);
    foreach (pl[i]) ps.push_back(pl[i]);
    ck = ~oc_sum(ps);
    th[16] = ck[15:8];
    th[17] = ck[7:0];
    foreach (ih[i]) f.push_back(ih[i]);
    foreach (th[i]) f.push_back(th[i]);
    foreach (pl[i]) f.push_back(pl[i]);
    c = 32'hFFFF_FFFF;
    foreach (f[i]) c = crc_tab[c[7:0] ^ f[i]] ^ (c >> 8);
    c = ~c;
    for (int k = 0; k < 4; k++) f.push_back(c[k*8 +: 8]);
    return f;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic tcp_packet_info_s make_pkt(input bq_t pl);
    tcp_packet_info_s p;
    p.dst_mac      = {16'($urandom), $urandom};
    p.src_mac      = {16'($urandom), $urandom};
    p.src_ip       = $urandom;
    p.dst_ip       = $urandom;
    p.src_port     = 16'($urandom);
    p.dst_port     = 16'($urandom);
    p.seq_num      = $urandom;
    p.ack_num      = $urandom;
    p.tcp_flags    = 8'($urandom);
    p.window       = 16'($urandom);
    p.payload_len  = 16'(pl.size());
    p.tcp_checksum = oc_sum(pl);
    return p;
  endfunction

  function automatic int count_diffs(input bq_t a, input bq_t b);
    int n, m;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic int count_lasts();
    int n = 0;
    foreach (lasts[i]) if (lasts[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus driver / collector ----------------
  task automatic run_frame(input tcp_packet_info_s p, input bq_t pl, input bit bp,
                           input int poke_at, input int rst_at, input int budget);
    bit         s_acc = 1'b1;
    bit         prev_stall = 1'b0;
    bit         done = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    int         pidx = 0;
    got.delete();
    lasts.delete();
    cycles = 0; first_lat = -1; hold_viol = 0; idle_viol = 0; sready_viol = 0;
    taken = 0; timed_out = 1'b0; aborted = 1'b0; rst_snap = '0;
    @(negedge clk);
    i_pkt = p;
    start = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int cyc = 1; cyc <= budget && !done && !aborted; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_at);
      if (cyc == poke_at) i_pkt = ~p;
      if (rst_at >= 0 && got.size() == rst_at) begin
        rst_n = 1'b0;
        #1;
        rst_snap = {m_if.tvalid, m_if.tlast, s_if.tready, busy, m_if.tdata};
        aborted = 1'b1;
      end else begin
        m_if.tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!s_if.tvalid || s_acc) begin
          if (pidx < pl.size() && (!bp || $urandom_range(0, 2) != 0)) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = pl[pidx];
            s_if.tlast  = (pidx == pl.size() - 1);
          end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = 8'($urandom);
            s_if.tlast  = 1'b0;
          end
        end
        #1;
        if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_dat)) hold_viol++;
        if (m_if.tvalid && !busy) idle_viol++;
        if (s_if.tready && pl.size() == 0) sready_viol++;
        if (m_if.tvalid && first_lat < 0) first_lat = cyc;
        s_acc = s_if.tvalid && s_if.tready;
        if (s_acc) pidx++;
        if (m_if.tvalid && m_if.tready) begin
          got.push_back(m_if.tdata);
          lasts.push_back(m_if.tlast);
          done = m_if.tlast;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_dat   = m_if.tdata;
        cycles     = cyc;
      end
    end
    taken       = pidx;
    timed_out   = !done && !aborted;
    start       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_if.tlast); end
    checks++; if (m_if.tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h expected 00", m_if.tdata); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", s_if.tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({m_if.tvalid, busy} !== 2'b00) begin errors++; $display("FAIL idle_after_rst: got %b expected 00", {m_if.tvalid, busy}); end
  endtask

  task automatic test_no_payload();
    tcp_packet_info_s p;
    bq_t pl, exp;
    p = '0;
    p.dst_mac = 48'hAABBCCDDEEFF;  p.src_mac = 48'h112233445566;
    p.src_ip  = 32'hC0A80101;      p.dst_ip  = 32'hC0A80102;
    p.src_port = 16'd5000;         p.dst_port = 16'd80;
    p.seq_num = 32'h12345678;      p.ack_num = 32'h87654321;
    p.tcp_flags = 8'h10;           p.window = 16'd1000;
    exp = build_frame(p, pl);
    run_frame(p, pl, 1'b0, -1, -1, 200);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL np_timeout: got %b expected 0", timed_out); end
    checks++; if (got.size() !== 58) begin errors++; $display("FAIL np_len: got %0d expected 58", got.size()); end
    checks++; if ({got[16], got[17]} !== 16'h0028) begin errors++; $display("FAIL np_ip_len: got %h expected 0028", {got[16], got[17]}); end
    checks++; if ({got[24], got[25]} !== 16'hB77C) begin errors++; $display("FAIL np_ip_csum: got %h expected b77c", {got[24], got[25]}); end
    checks++; if (count_diffs(got, exp) !== 0) begin errors++; $display("FAIL np_frame: got %0d differing bytes expected 0", count_diffs(got, exp)); end
    checks++; if (lasts.size() == 0 || count_lasts() !== 1 || lasts[$] !== 1'b1) begin errors++; $display("FAIL np_tlast: got %0d tlast beats expected 1 on final byte", count_lasts()); end
    checks++; if (sready_viol !== 0) begin errors++; $display("FAIL np_s_tready: got %0d cycles high expected 0", sready_viol); end
    checks++; if (first_lat < 1 || first_lat > 3) begin errors++; $display("FAIL np_first_lat: got %0d expected 1..3", first_lat); end
    checks++; if (cycles !== first_lat + 57) begin errors++; $display("FAIL np_throughput: got %0d cycles expected %0d", cycles, first_lat + 57); end
  endtask

  task automatic test_odd_payload();
    tcp_packet_info_s p;
    bq_t pl, exp;
    int bad = 0;
    for (int i = 0; i < 7; i++) pl.push_back(8'(i));
    p = make_pkt(pl);
    p.tcp_checksum = 16'h0C09;
    exp = build_frame(p, pl);
    run_frame(p, pl, 1'b0, -1, -1, 200);
    for (int i = 0; i < 7; i++) if (got[54+i] !== 8'(i)) bad++;
    checks++; if (got.size() !== 65) begin errors++; $display("FAIL odd_len: got %0d expected 65", got.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL odd_payload_pos: got %0d wrong bytes expected 0", bad); end
    checks++; if ({got[50], got[51]} !== {exp[50], exp[51]}) begin errors++; $display("FAIL odd_tcp_csum: got %h expected %h", {got[50], got[51]}, {exp[50], exp[51]}); end
    checks++; if (count_diffs(got, exp) !== 0) begin errors++; $display("FAIL odd_frame: got %0d differing bytes expected 0", count_diffs(got, exp)); end
    checks++; if (taken !== 7) begin errors++; $display("FAIL odd_taken: got %0d expected 7", taken); end
  endtask

  task automatic test_large_payload();
    tcp_packet_info_s p;
    bq_t pl, exp;
    for (int i = 0; i < 1000; i++) pl.push_back(8'(i));
    p = make_pkt(pl);
    exp = build_frame(p, pl);
    run_frame(p, pl, 1'b0, -1, -1, 1500);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL big_timeout: got %b expected 0", timed_out); end
    checks++; if (got.size() !== 1058) begin errors++; $display("FAIL big_len: got %0d expected 1058", got.size()); end
    checks++; if (cycles > 1500) begin errors++; $display("FAIL big_cycles: got %0d expected <=1500", cycles); end
    checks++; if (count_diffs(got, exp) !== 0) begin errors++; $display("FAIL big_frame: got %0d differing bytes expected 0", count_diffs(got, exp)); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      tcp_packet_info_s p;
      bq_t pl, exp;
      if (n % 2 == 1) pl = rand_payload(3 * n + 1);
      p = make_pkt(pl);
      p.src_port = 16'(5000 + n);
      p.seq_num  = 32'h12345678 + 32'(n);
      exp = build_frame(p, pl);
      run_frame(p, pl, 1'b0, -1, -1, 300);
      checks++; if (count_diffs(got, exp) !== 0 || timed_out) begin errors++; $display("FAIL b2b_frame%0d: got %0d differing bytes expected 0", n, count_diffs(got, exp)); end
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy%0d: got %b expected 0", n, busy); end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 4; n++) begin
      tcp_packet_info_s p;
      bq_t pl, exp;
      pl = rand_payload((n == 0) ? 0 : $urandom_range(1, 60));
      p = make_pkt(pl);
      exp = build_frame(p, pl);
      run_frame(p, pl, 1'b1, -1, -1, 1000);
      checks++; if (count_diffs(got, exp) !== 0 || timed_out) begin errors++; $display("FAIL bp_frame%0d: got %0d differing bytes expected 0", n, count_diffs(got, exp)); end
      checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold%0d: got %0d violations expected 0", n, hold_viol); end
      checks++; if (taken !== pl.size()) begin errors++; $display("FAIL bp_taken%0d: got %0d expected %0d", n, taken, pl.size()); end
      checks++; if (idle_viol !== 0) begin errors++; $display("FAIL bp_idle_vld%0d: got %0d expected 0", n, idle_viol); end
    end
  endtask

  task automatic test_start_while_busy();
    tcp_packet_info_s p;
    bq_t pl, exp;
    int stray = 0;
    pl = rand_payload(12);
    p = make_pkt(pl);
    exp = build_frame(p, pl);
    run_frame(p, pl, 1'b0, 10, -1, 300);
    checks++; if (count_diffs(got, exp) !== 0 || timed_out) begin errors++; $display("FAIL swb_frame: got %0d differing bytes expected 0", count_diffs(got, exp)); end
    repeat (8) begin
      @(negedge clk);
      #1;
      if (m_if.tvalid || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL swb_extra_frame: got %0d active cycles expected 0", stray); end
  endtask

  task automatic test_reset_mid_frame();
    tcp_packet_info_s p;
    bq_t pl, exp;
    pl = rand_payload(20);
    p = make_pkt(pl);
    run_frame(p, pl, 1'b0, -1, 30, 300);
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL rmf_aborted: got %b expected 1", aborted); end
    checks++; if (rst_snap !== 12'h000) begin errors++; $display("FAIL rmf_outputs: got %h expected 000", rst_snap); end
    checks++; if (count_lasts() !== 0) begin errors++; $display("FAIL rmf_tlast: got %0d expected 0", count_lasts()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pl = rand_payload(5);
    p = make_pkt(pl);
    exp = build_frame(p, pl);
    run_frame(p, pl, 1'b0, -1, -1, 300);
    checks++; if (count_diffs(got, exp) !== 0 || timed_out) begin errors++; $display("FAIL rmf_clean_frame: got %0d differing bytes expected 0", count_diffs(got, exp)); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    i_pkt = '0;
    s_if.tdata = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    init_crc_tab();
    test_reset();
    test_no_payload();
    test_odd_payload();
    test_large_payload();
    test_back_to_back();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
